// File: rtl/dlx_pkg.sv
// Shared DLX pipeline types and constants.
//   hz_state_t : hazard controller FSM state encoding
//   REG_W      : register selector width
//   R0         : hard-wired zero register selector
//   BUB_W      : width of the load-use bubble counter (LOAD_BUBBLES <= 3)
package dlx_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] R0 = '0;
  localparam int unsigned BUB_W = 2;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in ID reads the register that a load in EX is
// about to write. r0 is hard-wired to zero and never creates a dependence.
// Ports:
//   i_rs1_id, i_rs2_id         : source register selectors in ID
//   i_use_rs1_id, i_use_rs2_id : ID instruction actually reads that source
//   i_rd_ex                    : destination register of EX instruction
//   i_load_ex                  : EX instruction is a load
//   o_hazard                   : load-use interlock required
module hazard_cmp
  import dlx_pkg::*;
(
  input  logic [REG_W-1:0] i_rs1_id,
  input  logic [REG_W-1:0] i_rs2_id,
  input  logic             i_use_rs1_id,
  input  logic             i_use_rs2_id,
  input  logic [REG_W-1:0] i_rd_ex,
  input  logic             i_load_ex,
  output logic             o_hazard
);

  logic w_match_rs1;
  logic w_match_rs2;

  assign w_match_rs1 = i_use_rs1_id && (i_rs1_id == i_rd_ex);
  assign w_match_rs2 = i_use_rs2_id && (i_rs2_id == i_rd_ex);
  assign o_hazard    = i_load_ex && (i_rd_ex != R0) && (w_match_rs1 || w_match_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock / flush controller for the 5-stage DLX core (beside ID).
// Handles load-use interlock, taken-branch squash resolved in EX, and
// data-memory wait states. Keeps a saturating stall-cycle counter and a
// sticky memory-timeout flag.
// Priority: reset > memory wait > taken branch > load-use hazard.
// Ports:
//   i_clk, i_reset        : clock (rising edge), synchronous active-high reset
//   i_rs1_id..i_use_rs2_id: ID source selectors and read enables
//   i_rd_ex, i_load_ex    : EX destination register / EX holds a load
//   i_pc_cmd_ex           : taken branch/jump resolved in EX
//   i_d_req_mem, i_d_ready: MEM data-port request / completion
//   o_stall_if, o_stall_id: hold PC+IF/ID, hold ID
//   o_bubble_ex           : load NOP into ID/EX
//   o_flush_id            : squash IF/ID
//   o_stall_ex_mem        : freeze EX/MEM and MEM/WB
//   o_mem_err             : sticky, memory wait reached MEM_TIMEOUT cycles
//   o_stall_cycles        : saturating count of cycles with o_stall_if=1
//   o_state               : current FSM state (debug)
module hazard_ctrl
  import dlx_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [REG_W-1:0] i_rs1_id,
  input  logic [REG_W-1:0] i_rs2_id,
  input  logic             i_use_rs1_id,
  input  logic             i_use_rs2_id,
  input  logic [REG_W-1:0] i_rd_ex,
  input  logic             i_load_ex,
  input  logic             i_pc_cmd_ex,
  input  logic             i_d_req_mem,
  input  logic             i_d_ready,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic             o_stall_ex_mem,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [1:0]       o_state
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t        r_state;
  hz_state_t        w_state_next;
  logic [BUB_W-1:0] r_bub_cnt;
  logic [BUB_W-1:0] w_bub_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic             r_mem_err;
  logic             w_mem_err_next;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] w_stall_cycles_next;

  logic w_hazard;
  logic w_memwait;
  logic w_wait_hit;

  hazard_cmp u_hazard_cmp (
    .i_rs1_id     (i_rs1_id),
    .i_rs2_id     (i_rs2_id),
    .i_use_rs1_id (i_use_rs1_id),
    .i_use_rs2_id (i_use_rs2_id),
    .i_rd_ex      (i_rd_ex),
    .i_load_ex    (i_load_ex),
    .o_hazard     (w_hazard)
  );

  assign w_memwait = i_d_req_mem && !i_d_ready;

  // FSM next state and command decode
  always_comb begin
    w_state_next   = r_state;
    w_bub_next     = r_bub_cnt;
    o_stall_if     = 1'b0;
    o_stall_id     = 1'b0;
    o_bubble_ex    = 1'b0;
    o_flush_id     = 1'b0;
    o_stall_ex_mem = 1'b0;

    if (i_reset) begin
      w_state_next = RUN;
      w_bub_next   = '0;
    end else if (w_memwait) begin
      // Freeze everything; any remaining load bubbles are kept for afterwards.
      o_stall_if     = 1'b1;
      o_stall_id     = 1'b1;
      o_stall_ex_mem = 1'b1;
      w_state_next   = MEM_WAIT;
    end else begin
      case (r_state)
        MEM_WAIT: begin
          // Access completes this cycle: release the pipe, resume pending bubbles.
          if (r_bub_cnt != '0) begin
            w_state_next = LOAD_STALL;
          end else begin
            w_state_next = RUN;
          end
        end

        LOAD_STALL: begin
          if (i_pc_cmd_ex) begin
            // Redirect wins: the stalled ID instruction is on the wrong path.
            o_flush_id   = 1'b1;
            o_bubble_ex  = 1'b1;
            w_bub_next   = '0;
            w_state_next = RUN;
          end else begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_bubble_ex = 1'b1;
            if (r_bub_cnt <= BUB_W'(1)) begin
              w_bub_next   = '0;
              w_state_next = RUN;
            end else begin
              w_bub_next = r_bub_cnt - BUB_W'(1);
            end
          end
        end

        default: begin
          // RUN, and the unused encoding which falls back to RUN.
          w_state_next = RUN;
          if (i_pc_cmd_ex) begin
            o_flush_id  = 1'b1;
            o_bubble_ex = 1'b1;
          end else if (w_hazard) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_bubble_ex = 1'b1;
            w_bub_next  = BUB_W'(LOAD_BUBBLES - 1);
            if (LOAD_BUBBLES > 1) begin
              w_state_next = LOAD_STALL;
            end
          end
        end
      endcase
    end
  end

  // Memory wait counter counts every cycle of an outstanding access, including
  // the first one seen in RUN; it saturates at MEM_TIMEOUT.
  always_comb begin
    w_wait_hit     = (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));
    w_wait_next    = '0;
    w_mem_err_next = r_mem_err;
    if (w_memwait) begin
      if (w_wait_hit) begin
        w_wait_next    = WAIT_W'(MEM_TIMEOUT);
        w_mem_err_next = 1'b1;
      end else begin
        w_wait_next = r_wait_cnt + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    w_stall_cycles_next = r_stall_cycles;
    if (o_stall_if && (r_stall_cycles != '1)) begin
      w_stall_cycles_next = r_stall_cycles + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= RUN;
      r_bub_cnt      <= '0;
      r_wait_cnt     <= '0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state        <= w_state_next;
      r_bub_cnt      <= w_bub_next;
      r_wait_cnt     <= w_wait_next;
      r_mem_err      <= w_mem_err_next;
      r_stall_cycles <= w_stall_cycles_next;
    end
  end

  assign o_mem_err      = r_mem_err;
  assign o_stall_cycles = r_stall_cycles;
  assign o_state        = r_state;

endmodule
